// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and the round-robin search
// for the fifo write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int RR_MAX     = 8;

  // First set bit of valid_vec strictly after last,
  // wrapping modulo n. Returns last when nothing is set.
  function automatic logic [2:0] rr_next(
    input logic [7:0] valid_vec,
    input logic [2:0] last,
    input logic [3:0] n
  );
    logic [2:0] pick;
    logic       found;
    logic [3:0] idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX; k++) begin
      idx = {1'b0, last} + 4'(k);
      if (idx >= n) idx = idx - n;
      if (4'(k) <= n && !found &&
          valid_vec[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority search.
// Ports: i_valid requests, i_last previous winner,
// o_grant next winner, o_any any request pending.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int GW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [GW-1:0]    i_last,
  output logic [GW-1:0]    o_grant,
  output logic             o_any
);

  logic [7:0] w_vec;
  logic [2:0] w_last;
  logic [2:0] w_pick;
  logic       w_unused_pick;

  always_comb begin
    w_vec              = '0;
    w_vec[N_REQ-1:0]   = i_valid;
    w_last             = '0;
    w_last[GW-1:0]     = i_last;
  end

  assign w_pick        = rr_next(w_vec, w_last,
                                 4'(N_REQ));
  assign o_grant       = w_pick[GW-1:0];
  assign o_any         = |i_valid;
  assign w_unused_pick = ^w_pick;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of
// the fifo write port among N_REQ producers.
// Ports: clk, reset (sync, active-high); req_valid,
// req_data, req_ready per producer; fifo_full in;
// fifo_wr, fifo_w_data out; grant_id, busy status.
// Optional FIFO_ARB_STATS_EN adds stat_beats (16b per
// producer) and stat_full_stall saturating counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int MAX_BURST = 4,
  parameter  int DATA_W    = DEF_DATA_W,
  localparam int GW        = $clog2(N_REQ),
  localparam int BW        = $clog2(MAX_BURST) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr,
  output logic [DATA_W-1:0]       fifo_w_data,
  output logic [GW-1:0]           grant_id,
  output logic                    busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]     stat_beats,
  output logic [15:0]             stat_full_stall
`endif
);

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_grant, w_grant_nxt;
  logic [GW-1:0]   r_last, w_last_nxt;
  logic [GW-1:0]   w_pick;
  logic [BW-1:0]   r_beat, w_beat_nxt;
  logic            w_any;
  logic            w_acc;
  logic            w_gvalid;
  logic [N_REQ-1:0] w_ready;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .i_valid(req_valid),
    .i_last (r_last),
    .o_grant(w_pick),
    .o_any  (w_any)
  );

  always_comb begin
    w_ready  = '0;
    w_gvalid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant == GW'(i)) begin
        w_gvalid   = req_valid[i];
        w_ready[i] = (r_state == BURST) &&
                     !fifo_full;
      end
    end
  end

  assign w_acc = |(req_valid & w_ready);

  always_comb begin
    fifo_w_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_acc && r_grant == GW'(i))
        fifo_w_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_beat_nxt  = r_beat;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_beat_nxt  = '0;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        if (w_acc) begin
          w_beat_nxt = r_beat + 1'b1;
          if (r_beat == BW'(MAX_BURST - 1)) begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_grant;
          end
        end else if (!w_gvalid) begin
          // early release, also while stalled on full
          w_state_nxt = IDLE;
          w_last_nxt  = r_grant;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= GW'(N_REQ - 1);
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  assign req_ready = w_ready;
  assign fifo_wr   = w_acc;
  assign grant_id  = r_grant;
  assign busy      = (r_state == BURST);

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] r_stat_beats [N_REQ];
  logic [15:0] r_stat_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++)
        r_stat_beats[i] <= '0;
      r_stat_stall <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && w_ready[i] &&
            r_stat_beats[i] != 16'hFFFF)
          r_stat_beats[i] <= r_stat_beats[i] + 1'b1;
      end
      if (r_state == BURST && fifo_full &&
          r_stat_stall != 16'hFFFF)
        r_stat_stall <= r_stat_stall + 1'b1;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_beats[g*16 +: 16] = r_stat_beats[g];
  end
  assign stat_full_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: vector table, hand sequences and
// a data scoreboard for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        full_drv;
  logic        fifo_wr;
  logic [7:0]  fifo_w_data;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef FIFO_ARB_STATS_EN
  logic [63:0] stat_beats;
  logic [15:0] stat_full_stall;
`endif

  int          n_vec = 0;
  int          n_bad = 0;
  logic        sb_en = 1'b1;
  logic        use_model = 1'b0;
  int          m_cnt = 0;
  logic [7:0]  sb[$];
  logic [7:0]  mq[$];

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       f;
    logic [3:0] rdy;
    logic       wr;
    logic       bsy;
    logic [1:0] gid;
    logic [7:0] dat;
  } vec_t;

  vec_t tbl[24];

  always #5 clk = ~clk;

  assign fifo_full = use_model ? (m_cnt >= 8)
                               : full_drv;

  fifo_wr_arbiter #(
    .N_REQ(4),
    .MAX_BURST(4),
    .DATA_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_full(fifo_full),
    .fifo_wr(fifo_wr),
    .fifo_w_data(fifo_w_data),
    .grant_id(grant_id),
    .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    ,.stat_beats(stat_beats),
    .stat_full_stall(stat_full_stall)
`endif
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h",
               nm, $time, act, exp);
    end
  endtask

  // simple fifo model: accepts writes, full at 8
  always @(posedge clk) begin
    if (use_model && fifo_wr) begin
      mq.push_back(fifo_w_data);
      m_cnt <= m_cnt + 1;
    end
  end

  // scoreboard and protocol monitor
  always @(negedge clk) begin
    chk("ready_onehot0",
        32'($onehot0(req_ready)), 1);
    if (fifo_wr) begin
      chk("wr_while_full", 32'(fifo_full), 0);
      if (sb_en) begin
        if (sb.size() == 0)
          chk("sb_unexpected_wr", 1, 0);
        else
          chk("sb_data", fifo_w_data,
              sb.pop_front());
      end
    end
  end

  function automatic vec_t mk(
    input logic r, input logic [3:0] v,
    input logic f, input logic [3:0] rdy,
    input logic wr, input logic bsy,
    input logic [1:0] gid, input logic [7:0] dat);
    vec_t t;
    t.rst = r; t.v = v; t.f = f;
    t.rdy = rdy; t.wr = wr; t.bsy = bsy;
    t.gid = gid; t.dat = dat;
    return t;
  endfunction

  task automatic step(
    input logic r, input logic [3:0] v,
    input logic f, input logic [3:0] erdy,
    input logic ewr, input logic ebsy,
    input logic [1:0] egid, input logic gchk,
    input logic [7:0] edat);
    reset     = r;
    req_valid = v;
    full_drv  = f;
    if (ewr) sb.push_back(edat);
    @(negedge clk);
    chk("req_ready", req_ready, erdy);
    chk("fifo_wr", fifo_wr, ewr);
    chk("busy", busy, ebsy);
    if (gchk) chk("grant_id", grant_id, egid);
    chk("fifo_w_data", fifo_w_data, edat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int g;
    logic idle;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    full_drv = 1'b0;

    // reset hold, early release, full stall, re-win
    for (int i = 0; i < 6; i++)
      tbl[i] = mk(1, 4'hF, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 4'hC, 0, 0,    0, 0, 0, 0);
    tbl[7]  = mk(0, 4'hC, 0, 4'h4, 1, 1, 2, 8'h12);
    tbl[8]  = mk(0, 4'hC, 0, 4'h4, 1, 1, 2, 8'h12);
    tbl[9]  = mk(0, 4'h8, 0, 4'h4, 0, 1, 2, 0);
    tbl[10] = mk(0, 4'h8, 0, 0,    0, 0, 2, 0);
    tbl[11] = mk(0, 4'h8, 0, 4'h8, 1, 1, 3, 8'h13);
    tbl[12] = mk(0, 4'h8, 0, 4'h8, 1, 1, 3, 8'h13);
    for (int i = 13; i < 18; i++)
      tbl[i] = mk(0, 4'h8, 1, 0, 0, 1, 3, 0);
    tbl[18] = mk(0, 4'h8, 0, 4'h8, 1, 1, 3, 8'h13);
    tbl[19] = mk(0, 4'h8, 0, 4'h8, 1, 1, 3, 8'h13);
    tbl[20] = mk(0, 4'h8, 0, 0,    0, 0, 3, 0);
    tbl[21] = mk(0, 4'h8, 0, 4'h8, 1, 1, 3, 8'h13);
    tbl[22] = mk(0, 4'h0, 1, 0,    0, 1, 3, 0);
    tbl[23] = mk(0, 4'h0, 0, 0,    0, 0, 3, 0);

    for (int i = 0; i < 24; i++)
      step(tbl[i].rst, tbl[i].v, tbl[i].f,
           tbl[i].rdy, tbl[i].wr, tbl[i].bsy,
           tbl[i].gid, 1'b1, tbl[i].dat);

    // round-robin bursts 0,1,2,3,0 with idle gaps
    for (int c = 0; c < 25; c++) begin
      idle = (c % 5 == 0);
      g    = (c / 5) % 4;
      step(0, 4'hF, 0,
           idle ? 4'h0 : 4'(1 << g),
           !idle, !idle, 2'(g), !idle,
           idle ? 8'h00 : 8'(8'h10 + g));
    end

    // mid-burst reset during beat 3 of producer 1
    step(0, 4'hF, 0, 0,    0, 0, 0, 0, 0);
    step(0, 4'hF, 0, 4'h2, 1, 1, 1, 1, 8'h11);
    step(0, 4'hF, 0, 4'h2, 1, 1, 1, 1, 8'h11);
    step(1, 4'hF, 0, 4'h2, 1, 1, 1, 1, 8'h11);
    step(0, 4'hF, 0, 0,    0, 0, 0, 1, 0);
    step(0, 4'hF, 0, 4'h1, 1, 1, 0, 1, 8'h10);
    step(0, 4'h0, 0, 4'h1, 0, 1, 0, 1, 0);
    step(0, 4'h0, 0, 0,    0, 0, 0, 1, 0);
    chk("sb_drained", sb.size(), 0);

    // fifo integration: producer 1 offers 1..A
    sb_en     = 1'b0;
    use_model = 1'b1;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      req_valid       = (k < 10) ? 4'h2 : 4'h0;
      req_data[15:8]  = 8'(k + 1);
      @(negedge clk);
      if (req_valid[1] && req_ready[1]) k++;
      @(posedge clk);
      #1;
    end
    chk("accepted_beats", k, 8);
    chk("fifo_depth", mq.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (mq.size() > 0)
        chk("readback", mq.pop_front(), i + 1);
      else
        chk("readback_empty", 0, 1);
    end

    reset     = 1'b1;
    req_valid = 4'h0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single 8-bit write port of the existing `fifo` block among N producers.
- Round-robin arbitration with bounded bursts: a granted producer may write up to MAX_BURST consecutive beats, then the grant passes on.
- Sits directly in front of `fifo`: drives its wr/w_data and observes its full flag.
- The read side of `fifo` is untouched.

Parameters:
- N_REQ, 4, number of producers (2..8)
- MAX_BURST, 4, maximum beats per grant (1..16)
- DATA_W, 8, data width; must match the `fifo` w_data width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  per-producer data valid
- req_data  input  N_REQ*DATA_W  packed producer data; producer i occupies bits [i*DATA_W +: DATA_W]
- req_ready  output  N_REQ  per-producer accept, one-hot or zero
- fifo_full  input  1  full flag from `fifo`
- fifo_wr  output  1  write strobe to `fifo`
- fifo_w_data  output  DATA_W  write data to `fifo`
- grant_id  output  $clog2(N_REQ)  currently granted producer
- busy  output  1  high while in BURST state

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high.
- Reset values:
  - state=IDLE, busy=0, req_ready=0, fifo_wr=0, fifo_w_data=0, grant_id=0, beat_cnt=0.
  - last_grant=N_REQ-1, so producer 0 has first priority.
- Handshake: beat i is accepted on a rising edge where req_valid[i] && req_ready[i].
  - Producers hold req_valid and req_data stable until accepted.
- req_ready[i] is combinational: state==BURST && grant_id==i && !fifo_full.
- fifo_wr = |(req_valid & req_ready), combinational.
  - fifo_w_data = granted slice of req_data when fifo_wr=1, otherwise 0.
  - Write latency into `fifo` is 0 cycles: the same edge as the accept.
- Never assert fifo_wr while fifo_full=1.
- State machine:
  - IDLE:
    - If any req_valid is set, select the first set bit searching from last_grant+1 upward, wrapping modulo N_REQ.
    - Register it into grant_id, clear beat_cnt, go to BURST.
    - Arbitration costs exactly 1 cycle, during which req_ready=0.
    - If no req_valid is set, stay in IDLE.
  - BURST, on an accept:
    - beat_cnt increments.
    - If beat_cnt==MAX_BURST-1 at the accept, go to IDLE and set last_grant=grant_id.
  - BURST, granted producer has req_valid=0 with no accept this cycle: go to IDLE and set last_grant=grant_id (early release).
  - BURST, fifo_full=1: stall in BURST. beat_cnt, grant and last_grant hold; no timeout.
- Boundary conditions:
  - Valid from non-granted producers is ignored; their req_ready stays 0.
  - fifo_full rising mid-burst pauses the burst; deasserting fifo_full resumes it in the same cycle.
  - A granted producer dropping valid while fifo_full=1 releases the grant.
  - A single active producer re-wins after one IDLE cycle between bursts.
  - Round-robin wrap: after grant N_REQ-1, search restarts at 0.
  - Reset asserted mid-burst clears everything in the same edge; the partially written burst is not rolled back.
- beat_cnt width is $clog2(MAX_BURST)+1. grant_id, last_grant and the search index wrap modulo N_REQ.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - Adds output stat_beats, N_REQ*16 bits: per-producer saturating counters of accepted beats, cleared by reset.
  - Adds output stat_full_stall, 16 bits: saturating count of BURST cycles spent with fifo_full=1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg:
  - state enum (IDLE, BURST)
  - DATA_W default constant
  - function rr_next(valid_vec, last) returning the next grant index
- One sub-module: rr_pick, the combinational round-robin priority search.
  - Reusable by a future read-side scheduler.
  - Everything else stays in fifo_wr_arbiter.

Test Plan:
- Reset hold:
  - Stimulus: reset=1 for 6 cycles with all req_valid=1.
  - Response: req_ready=0, fifo_wr=0, busy=0 throughout. After release, first grant_id=0 following 1 IDLE cycle.
- Round-robin bursts:
  - Stimulus: MAX_BURST=4, all 4 producers continuously valid with data 8'h10+i.
  - Response: fifo writes 4 beats from producer 0, then 4 from 1, 2, 3, then back to 0; one idle cycle between bursts; fifo_w_data matches the granted producer.
- Early release:
  - Stimulus: producer 2 valid for 2 beats only, producer 3 continuously valid.
  - Response: 2 writes of producer 2 data, then IDLE, then grant_id=3.
- Full stall:
  - Stimulus: fifo_full forced to 1 for 5 cycles after beat 2 of a burst.
  - Response: fifo_wr=0 and req_ready=0 for those 5 cycles. The burst resumes and writes exactly 2 more beats.
- Real fifo integration:
  - Stimulus: connect to `fifo` and write 10 beats (8'h1..8'hA) from producer 1 until full asserts.
  - Response: no write attempted while full. Reading the fifo back returns the accepted values in order.
- Mid-burst reset:
  - Stimulus: assert reset during beat 3.
  - Response: busy=0 and req_ready=0 on the next edge. The next grant after release goes to producer 0 when it is valid.
